// File: rtl/q_fixed_pkg.sv
// Shared Q16.48 fixed-point definitions: widths, special-value codes and the
// divider state type. The combinational multiplier uses the same constants.
package q_fixed_pkg;

    localparam int Q_WIDTH = 64;
    localparam int Q_FRAC  = 48;

    // Special-value encoding shared by the whole fixed-point datapath.
    localparam logic [Q_WIDTH-1:0] Q_NAN     = 64'h8000_0000_0000_0000;
    localparam logic [Q_WIDTH-1:0] Q_POS_INF = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [Q_WIDTH-1:0] Q_NEG_INF = 64'hFFFF_FFFF_FFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } q_div_state_t;

endpackage

// File: rtl/q_special_case.sv
// Combinational classification of a Q16.48 division a / b into NaN, +/-Inf,
// zero and overflow outcomes. When is_special is low the operands need a real
// division and special_res is don't-care (driven to zero).
module q_special_case
    import q_fixed_pkg::*;
#(
    parameter int WIDTH     = Q_WIDTH,
    parameter int FRAC_BITS = Q_FRAC
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             is_special,
    output logic [WIDTH-1:0] special_res,
    output logic             neg
);

    // Integer bits minus one: |a| >= |b| << OVF_SHIFT means the quotient
    // cannot be represented.
    localparam int OVF_SHIFT = WIDTH - FRAC_BITS - 1;
    localparam int WIDE      = WIDTH + OVF_SHIFT;

    logic             w_a_nan;
    logic             w_b_nan;
    logic             w_a_inf;
    logic             w_b_inf;
    logic             w_a_zero;
    logic             w_b_zero;
    logic             w_ovf;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_signed_inf;
    logic [WIDE-1:0]  w_a_wide;
    logic [WIDE-1:0]  w_b_scaled;

    assign w_a_nan  = (a == Q_NAN);
    assign w_b_nan  = (b == Q_NAN);
    assign w_a_inf  = (a == Q_POS_INF) || (a == Q_NEG_INF);
    assign w_b_inf  = (b == Q_POS_INF) || (b == Q_NEG_INF);
    assign w_a_zero = (a == '0);
    assign w_b_zero = (b == '0);

    assign w_mag_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_mag_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    // Compare in a widened domain so the scaled divisor never loses bits.
    assign w_a_wide   = {{OVF_SHIFT{1'b0}}, w_mag_a};
    assign w_b_scaled = {w_mag_b, {OVF_SHIFT{1'b0}}};
    assign w_ovf      = (w_a_wide >= w_b_scaled);

    assign neg          = a[WIDTH-1] ^ b[WIDTH-1];
    assign w_signed_inf = neg ? Q_NEG_INF : Q_POS_INF;

    // Priority classification; the first matching rule decides the result.
    always_comb begin
        is_special  = 1'b1;
        special_res = '0;
        if (w_a_nan || w_b_nan) begin
            special_res = Q_NAN;
        end else if (w_a_inf && w_b_inf) begin
            special_res = Q_NAN;
        end else if (w_b_zero) begin
            // x/0 takes the sign of the dividend alone; 0/0 is undefined.
            special_res = w_a_zero ? Q_NAN : (a[WIDTH-1] ? Q_NEG_INF : Q_POS_INF);
        end else if (w_a_inf) begin
            special_res = w_signed_inf;
        end else if (w_b_inf) begin
            special_res = '0;
        end else if (w_ovf) begin
            special_res = w_signed_inf;
        end else begin
            is_special = 1'b0;
        end
    end

endmodule

// File: rtl/q15_divider_seq.sv
// Sequential signed Q16.48 divider, res = a / b, radix-2 restoring division
// on magnitudes with one quotient bit per cycle and a final sign fix.
//
// Handshake: an operand pair is taken on a rising edge where in_valid and
// in_ready are both high; in_ready is high only in IDLE (and out of reset).
// The result is offered with out_valid and held, together with res, until an
// edge where out_ready is high; that edge returns to IDLE, so a new operand
// pair can be accepted one cycle later at the earliest.
module q15_divider_seq
    import q_fixed_pkg::*;
#(
    parameter int WIDTH     = Q_WIDTH,
    parameter int FRAC_BITS = Q_FRAC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    localparam int QW        = WIDTH - 1;
    localparam int OVF_SHIFT = WIDTH - FRAC_BITS - 1;
    localparam int CNT_W     = $clog2(WIDTH);
    // Iterations use counts 0..WIDTH-2; the count WIDTH-1 marks the sign-fix edge.
    localparam logic [CNT_W-1:0] SIGN_STEP = CNT_W'(WIDTH - 1);

    q_div_state_t     r_state;
    // Remainder is held at full divisor width: with a large |b| the partial
    // remainder can grow well past the 48 bits of the initial value.
    logic [WIDTH-1:0] r_rem;
    // Holds the not-yet-consumed dividend bits at the top and collects
    // quotient bits at the bottom; after QW shifts it is pure quotient.
    logic [QW-1:0]    r_quot;
    logic [WIDTH-1:0] r_mag_b;
    logic [WIDTH-1:0] r_res;
    logic [CNT_W-1:0] r_cnt;
    logic             r_neg;
    logic             r_out_valid;

    logic             w_is_special;
    logic             w_neg;
    logic [WIDTH-1:0] w_special_res;
    logic [WIDTH-1:0] w_mag_a;
    logic [WIDTH-1:0] w_mag_b;
    logic [WIDTH-1:0] w_rem_init;
    logic [QW-1:0]    w_quot_init;
    logic [WIDTH:0]   w_shifted;
    logic [WIDTH:0]   w_divisor;
    logic             w_fits;
    logic [WIDTH-1:0] w_rem_next;
    logic [QW-1:0]    w_quot_next;
    logic [WIDTH-1:0] w_quot_ext;
    logic [WIDTH-1:0] w_signed_q;

    q_special_case #(
        .WIDTH     (WIDTH),
        .FRAC_BITS (FRAC_BITS)
    ) u_special (
        .a           (a),
        .b           (b),
        .is_special  (w_is_special),
        .special_res (w_special_res),
        .neg         (w_neg)
    );

    assign w_mag_a = a[WIDTH-1] ? (~a + WIDTH'(1)) : a;
    assign w_mag_b = b[WIDTH-1] ? (~b + WIDTH'(1)) : b;

    // The top bits of |a| can never produce a quotient bit (non-overflow
    // guarantees they are below |b|), so they seed the remainder directly.
    assign w_rem_init  = w_mag_a >> OVF_SHIFT;
    assign w_quot_init = {w_mag_a[OVF_SHIFT-1:0], {FRAC_BITS{1'b0}}};

    // One restoring step: shift in the next dividend bit, subtract if it fits.
    assign w_shifted   = {r_rem, r_quot[QW-1]};
    assign w_divisor   = {1'b0, r_mag_b};
    assign w_fits      = (w_shifted >= w_divisor);
    assign w_rem_next  = w_fits ? WIDTH'(w_shifted - w_divisor) : w_shifted[WIDTH-1:0];
    assign w_quot_next = {r_quot[QW-2:0], w_fits};

    // A zero magnitude stays +0 regardless of the operand signs.
    assign w_quot_ext = {1'b0, r_quot};
    assign w_signed_q = (r_neg && (r_quot != '0)) ? (~w_quot_ext + WIDTH'(1)) : w_quot_ext;

    // Control FSM with the datapath registers and the registered result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_rem       <= '0;
            r_quot      <= '0;
            r_mag_b     <= '0;
            r_res       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_neg   <= w_neg;
                        r_mag_b <= w_mag_b;
                        r_cnt   <= '0;
                        if (w_is_special) begin
                            r_res       <= w_special_res;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_rem   <= w_rem_init;
                            r_quot  <= w_quot_init;
                            r_state <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    if (r_cnt == SIGN_STEP) begin
                        r_res       <= w_signed_q;
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_rem  <= w_rem_next;
                        r_quot <= w_quot_next;
                        r_cnt  <= r_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready  = rst_n && (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign out_valid = r_out_valid;
    assign res       = r_res;
    assign dbg_state = r_state;

endmodule
